// File: rtl/mvm_feeder.sv
// mvm_feeder: walks the (o, h, i) tile loops of one layer pass, reading activation
// and weight words from the buffers and streaming them to the MVM array.
`ifndef MAX_DW
`define MAX_DW 8
`endif
`ifndef Tin
`define Tin 4
`endif
`ifndef Tout
`define Tout 4
`endif
`ifndef log2_Height_max
`define log2_Height_max 8
`endif
`ifndef log2_Width_max
`define log2_Width_max 8
`endif
`ifndef log2_Tin
`define log2_Tin 2
`endif

module mvm_feeder #(
  parameter int DAT_AW = 12,
  parameter int WT_AW  = 12
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic                                    pause,
  input  logic [`log2_Height_max-1:0]             height,
  input  logic [`log2_Width_max-`log2_Tin-1:0]    Win_div_Tin,
  input  logic [`log2_Width_max-`log2_Tin-1:0]    Wout_div_Tout,
  input  logic [DAT_AW-1:0]                       dat_base,
  input  logic [WT_AW-1:0]                        wt_base,
  output logic                                    dat_rd_en,
  output logic [DAT_AW-1:0]                       dat_rd_addr,
  input  logic [`MAX_DW*`Tin-1:0]                 dat_rd_data,
  output logic                                    wt_rd_en,
  output logic [WT_AW-1:0]                        wt_rd_addr,
  input  logic [`MAX_DW*`Tin*`Tout-1:0]           wt_rd_data,
  output logic                                    dat_vld,
  output logic [`MAX_DW*`Tin-1:0]                 dat,
  output logic                                    wt_vld,
  output logic [`MAX_DW*`Tin*`Tout-1:0]           wt,
  output logic                                    busy,
  output logic                                    done
);

  localparam int HW  = `log2_Height_max;
  localparam int WW  = `log2_Width_max - `log2_Tin;
  localparam int DW  = `MAX_DW * `Tin;
  localparam int WTW = `MAX_DW * `Tin * `Tout;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [HW-1:0]     cfg_h;
  logic [WW-1:0]     cfg_wi;
  logic [WW-1:0]     cfg_wo;
  logic [DAT_AW-1:0] cfg_dat_base;

  logic [HW-1:0]     h_cnt;
  logic [WW-1:0]     i_cnt;
  logic [WW-1:0]     o_cnt;
  logic [DAT_AW-1:0] dat_ptr;
  logic [WT_AW-1:0]  wt_ptr;
  logic [WT_AW-1:0]  wt_row;

  logic              cfg_zero;
  logic              accept;
  logic              beat;
  logic              last_i;
  logic              last_h;
  logic              last_o;
  logic              last_beat;
  logic              done_nxt;

  logic              rd_vld;
  logic [DW-1:0]     dat_hold;
  logic [WTW-1:0]    wt_hold;

  assign cfg_zero  = (height == '0) || (Win_div_Tin == '0) || (Wout_div_Tout == '0);
  assign accept    = (state == IDLE) && start && !cfg_zero;
  assign beat      = (state == RUN) && !pause;
  assign last_i    = (i_cnt == cfg_wi - WW'(1));
  assign last_h    = (h_cnt == cfg_h - HW'(1));
  assign last_o    = (o_cnt == cfg_wo - WW'(1));
  assign last_beat = beat && last_i && last_h && last_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start && cfg_zero) begin
          done_nxt = 1'b1;
        end else if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_beat) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pointers advance by one per beat; reloads at loop ends replace the
  // h*Wi and o*Wi products of the address formulas.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_h        <= '0;
      cfg_wi       <= '0;
      cfg_wo       <= '0;
      cfg_dat_base <= '0;
      h_cnt        <= '0;
      i_cnt        <= '0;
      o_cnt        <= '0;
      dat_ptr      <= '0;
      wt_ptr       <= '0;
      wt_row       <= '0;
    end else if (accept) begin
      cfg_h        <= height;
      cfg_wi       <= Win_div_Tin;
      cfg_wo       <= Wout_div_Tout;
      cfg_dat_base <= dat_base;
      h_cnt        <= '0;
      i_cnt        <= '0;
      o_cnt        <= '0;
      dat_ptr      <= dat_base;
      wt_ptr       <= wt_base;
      wt_row       <= wt_base;
    end else if (beat) begin
      if (!last_i) begin
        i_cnt   <= i_cnt + WW'(1);
        dat_ptr <= dat_ptr + DAT_AW'(1);
        wt_ptr  <= wt_ptr + WT_AW'(1);
      end else begin
        i_cnt <= '0;
        if (!last_h) begin
          h_cnt   <= h_cnt + HW'(1);
          dat_ptr <= dat_ptr + DAT_AW'(1);
          wt_ptr  <= wt_row;
        end else begin
          h_cnt   <= '0;
          o_cnt   <= o_cnt + WW'(1);
          dat_ptr <= cfg_dat_base;
          wt_row  <= wt_row + WT_AW'(cfg_wi);
          wt_ptr  <= wt_row + WT_AW'(cfg_wi);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld   <= 1'b0;
      done     <= 1'b0;
      dat_hold <= '0;
      wt_hold  <= '0;
    end else begin
      rd_vld <= beat;
      done   <= done_nxt;
      if (rd_vld) begin
        dat_hold <= dat_rd_data;
        wt_hold  <= wt_rd_data;
      end
    end
  end

  // Beat data passes straight through while valid and is held afterwards.
  assign dat         = rd_vld ? dat_rd_data : dat_hold;
  assign wt          = rd_vld ? wt_rd_data  : wt_hold;
  assign dat_vld     = rd_vld;
  assign wt_vld      = rd_vld;
  assign dat_rd_en   = beat;
  assign wt_rd_en    = beat;
  assign dat_rd_addr = dat_ptr;
  assign wt_rd_addr  = wt_ptr;
  assign busy        = (state != IDLE);

endmodule

// File: doc/mvm_feeder.md
Name: mvm_feeder

Overview:
- Sequencer at the input end of the MVM array.
- Reads activation tiles from a data buffer and weight tiles from a weight buffer, then drives the MVM input stream (dat_vld, dat, wt_vld, wt) in the loop order the MVM FSM expects.
- Provides start/busy/done control for the layer controller and a pause input for buffer refill.

Parameters:
- DAT_AW, 12, data-buffer word address width
- WT_AW, 12, weight-buffer word address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; launches one layer pass when idle
- pause  in  1  high = issue no new buffer reads this cycle
- height  in  `log2_Height_max  number of rows H
- Win_div_Tin  in  `log2_Width_max-`log2_Tin  input tiles per row Wi
- Wout_div_Tout  in  `log2_Width_max-`log2_Tin  output tiles Wo
- dat_base  in  DAT_AW  data-buffer start address
- wt_base  in  WT_AW  weight-buffer start address
- dat_rd_en  out  1  data-buffer read strobe
- dat_rd_addr  out  DAT_AW  data-buffer read address
- dat_rd_data  in  `MAX_DW*`Tin  data word, valid 1 cycle after dat_rd_en
- wt_rd_en  out  1  weight-buffer read strobe
- wt_rd_addr  out  WT_AW  weight-buffer read address
- wt_rd_data  in  `MAX_DW*`Tin*`Tout  weight word, valid 1 cycle after wt_rd_en
- dat_vld  out  1  activation beat valid (to MVM)
- dat  out  `MAX_DW*`Tin  activation beat
- wt_vld  out  1  weight beat valid (to MVM)
- wt  out  `MAX_DW*`Tin*`Tout  weight beat
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset (async, rst_n low): state IDLE; all counters and pointers 0; every output 0.
- Config (height, Win_div_Tin, Wout_div_Tout, dat_base, wt_base) latched on the accepted start. Later input changes are ignored until the next pass.
- Loop order, i innermost: for o in 0..Wo-1, for h in 0..H-1, for i in 0..Wi-1:
  - dat_rd_addr = dat_base + h*Wi + i
  - wt_rd_addr = wt_base + o*Wi + i
  - Total beats = H*Wi*Wo.
- Addresses are generated incrementally, with no multipliers:
  - dat pointer +1 per beat; reloads dat_base at the end of each h loop.
  - wt pointer +1 per beat; reloads wt row base at the end of each i loop.
  - wt row base += Wi at the end of each h loop.
  - All address arithmetic wraps modulo 2^AW.
- FSM IDLE -> RUN -> DRAIN -> IDLE:
  - IDLE: busy=0. start with all of H, Wi, Wo nonzero -> RUN. start with any of them zero -> done pulses next cycle, no reads, stay IDLE.
  - RUN: busy=1. Each cycle with pause=0, assert dat_rd_en and wt_rd_en together and advance counters. With pause=1, no read and counters hold. When the last beat's read issues -> DRAIN.
  - DRAIN: busy=1, one cycle; the last beat is presented. Next cycle: done=1, busy=0, state IDLE.
- Output timing:
  - dat_vld = wt_vld = the read strobe registered by 1 cycle.
  - dat/wt = rd_data captured in that cycle, and held when valid is low.
  - dat_vld and wt_vld are always identical.
- Latency:
  - start sampled in cycle 0.
  - First read in cycle 1.
  - First dat_vld in cycle 2.
  - With no pause, done is asserted in cycle H*Wi*Wo+2.
- pause during RUN:
  - Creates bubbles only; the beat order is unchanged.
  - A read issued in the cycle before pause rises is still delivered.
  - pause is ignored in IDLE and DRAIN.
- start while busy: ignored, no restart, config unchanged.
- start in the same cycle as done: accepted; the new pass begins.
- Reset mid-pass: immediate return to IDLE; outputs 0; no done pulse.

Test Plan:
- H=2, Wi=3, Wo=2, dat_base=0x10, wt_base=0x100, pause=0:
  - 12 beats.
  - dat addrs 0x10..0x15, then 0x10..0x15.
  - wt addrs 0x100..0x102 twice, then 0x103..0x105 twice.
  - done at cycle 14.
- Same config, pause high on cycles 3-5:
  - Identical address/data sequence with a 3-cycle gap in dat_vld.
  - done at cycle 17.
- dat_base=0xFFE, H=1, Wi=4, Wo=1: dat addrs 0xFFE, 0xFFF, 0x000, 0x001 (wrap).
- Wi=0: done one cycle after start; dat_rd_en, dat_vld and busy never assert.
- start re-pulsed mid-pass with different config: ignored; the original 12-beat sequence completes unchanged.
- rst_n low during beat 5: all outputs 0 immediately, no done. A new start afterwards runs a full pass from beat 0.
